// File: rtl/regfile_port_ctrl_if.sv
// Request/response/writeback handshake bundle between a pipeline client and
// the register-file port controller.
interface regfile_port_ctrl_if;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [4:0]  rd_req_rs1;
    logic [4:0]  rd_req_rs2;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [31:0] rd_rsp_data1;
    logic [31:0] rd_rsp_data2;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_count;

    // Client side: issues reads and writebacks, consumes responses.
    modport master (
        output rd_req_valid, rd_req_rs1, rd_req_rs2, rd_rsp_ready,
               wb_valid, wb_rd, wb_data,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data1, rd_rsp_data2,
               wb_ready, wb_count
    );

    // Controller side.
    modport slave (
        input  rd_req_valid, rd_req_rs1, rd_req_rs2, rd_rsp_ready,
               wb_valid, wb_rd, wb_data,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data1, rd_rsp_data2,
               wb_ready, wb_count
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: one operand read at a time with fixed
// two-cycle latency, a 2-entry writeback queue drained whenever the read
// port is not in use, and bypass of queued writes into read responses.
module regfile_port_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    regfile_port_ctrl_if.slave    bus,
    output logic                  rf_en,
    output logic                  rf_reset,
    output logic                  rf_readEn,
    output logic                  rf_writeEn,
    output logic [4:0]            rf_rs1,
    output logic [4:0]            rf_rs2,
    output logic [4:0]            rf_rd,
    output logic [31:0]           rf_dataIn,
    input  logic [31:0]           rf_readOut1,
    input  logic [31:0]           rf_readOut2
);

    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_IDLE     = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_RSP   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [4:0]         rs1_r;
    logic [4:0]         rs2_r;
    logic               hit1_r;
    logic               hit2_r;
    logic [31:0]        byp1_r;
    logic [31:0]        byp2_r;

    // Entry 0 is the queue head (oldest), entry 1 the younger one.
    logic [1:0][4:0]    q_rd_r;
    logic [1:0][31:0]   q_data_r;
    logic [1:0]         q_cnt_r;

    logic               rd_req_ready_s;
    logic               wb_ready_s;
    logic               rd_accept_s;
    logic               wb_push_s;
    logic               drain_s;
    logic               rsp_hs_s;
    logic               rsp_valid_s;
    logic [32:0]        lookup1_s;
    logic [32:0]        lookup2_s;

    // Youngest queued entry targeting src wins; returns {hit, data}.
    function automatic logic [32:0] byp_lookup(
        input logic [4:0]        src,
        input logic [1:0]        cnt,
        input logic [1:0][4:0]   rds,
        input logic [1:0][31:0]  dats
    );
        logic [32:0] res;
        if ((cnt == 2'd2) && (rds[1] == src)) begin
            res = {1'b1, dats[1]};
        end else if ((cnt != 2'd0) && (rds[0] == src)) begin
            res = {1'b1, dats[0]};
        end else begin
            res = {1'b0, 32'd0};
        end
        return res;
    endfunction

    // Handshake qualifiers; everything is forced quiet while reset is high.
    always_comb begin
        rd_req_ready_s = ~reset & (state_r == ST_IDLE);
        wb_ready_s     = ~reset & (state_r != ST_CLEAR) & (q_cnt_r != 2'd2);
        rd_accept_s    = bus.rd_req_valid & rd_req_ready_s;
        wb_push_s      = bus.wb_valid & wb_ready_s & (bus.wb_rd != 5'd0);
        drain_s        = ~reset & ((state_r == ST_IDLE) | (state_r == ST_RD_RSP))
                         & (q_cnt_r != 2'd0);
        rsp_valid_s    = ~reset & (state_r == ST_RD_RSP);
        rsp_hs_s       = rsp_valid_s & bus.rd_rsp_ready;
        lookup1_s      = byp_lookup(rs1_r, q_cnt_r, q_rd_r, q_data_r);
        lookup2_s      = byp_lookup(rs2_r, q_cnt_r, q_rd_r, q_data_r);
    end

    // Next-state logic of the read sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR:    state_nxt_s = ST_IDLE;
            ST_IDLE:     state_nxt_s = rd_accept_s ? ST_RD_ISSUE : ST_IDLE;
            ST_RD_ISSUE: state_nxt_s = ST_RD_RSP;
            ST_RD_RSP:   state_nxt_s = rsp_hs_s ? ST_IDLE : ST_RD_RSP;
            default:     state_nxt_s = ST_CLEAR;
        endcase
    end

    // State register; reset always lands in CLEAR so the RF gets one clear cycle after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture source addresses when a read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_r <= 5'd0;
            rs2_r <= 5'd0;
        end else if (rd_accept_s) begin
            rs1_r <= bus.rd_req_rs1;
            rs2_r <= bus.rd_req_rs2;
        end else begin
            rs1_r <= rs1_r;
            rs2_r <= rs2_r;
        end
    end

    // Snapshot bypass hits against the queue as it stands during the issue cycle (nothing drains then).
    always_ff @(posedge clk) begin
        if (reset) begin
            hit1_r <= 1'b0;
            hit2_r <= 1'b0;
            byp1_r <= 32'd0;
            byp2_r <= 32'd0;
        end else if (state_r == ST_RD_ISSUE) begin
            hit1_r <= lookup1_s[32];
            byp1_r <= lookup1_s[31:0];
            hit2_r <= lookup2_s[32];
            byp2_r <= lookup2_s[31:0];
        end else begin
            hit1_r <= hit1_r;
            byp1_r <= byp1_r;
            hit2_r <= hit2_r;
            byp2_r <= byp2_r;
        end
    end

    // Writeback queue: push at tail, pop at head; push+pop only happens with one entry present.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_cnt_r  <= 2'd0;
            q_rd_r   <= '0;
            q_data_r <= '0;
        end else begin
            case ({wb_push_s, drain_s})
                2'b10: begin
                    q_rd_r[q_cnt_r[0]]   <= bus.wb_rd;
                    q_data_r[q_cnt_r[0]] <= bus.wb_data;
                    q_cnt_r              <= q_cnt_r + 2'd1;
                end
                2'b01: begin
                    q_rd_r[0]   <= q_rd_r[1];
                    q_data_r[0] <= q_data_r[1];
                    q_rd_r[1]   <= 5'd0;
                    q_data_r[1] <= 32'd0;
                    q_cnt_r     <= q_cnt_r - 2'd1;
                end
                2'b11: begin
                    q_rd_r[0]   <= bus.wb_rd;
                    q_data_r[0] <= bus.wb_data;
                    q_cnt_r     <= q_cnt_r;
                end
                default: begin
                    q_cnt_r <= q_cnt_r;
                end
            endcase
        end
    end

    // Register-file side drive; read and write strobes are mutually exclusive by state.
    always_comb begin
        rf_reset   = reset | (state_r == ST_CLEAR);
        rf_readEn  = ~reset & (state_r == ST_RD_ISSUE);
        rf_writeEn = drain_s;
        rf_en      = rf_reset | rf_readEn | rf_writeEn;
        rf_rs1     = rf_readEn ? rs1_r : 5'd0;
        rf_rs2     = rf_readEn ? rs2_r : 5'd0;
        rf_rd      = drain_s ? q_rd_r[0] : 5'd0;
        rf_dataIn  = drain_s ? q_data_r[0] : 32'd0;
    end

    // Response data: x0 reads zero, bypass beats the RF, zero whenever not valid.
    always_comb begin
        bus.rd_rsp_data1 = 32'd0;
        bus.rd_rsp_data2 = 32'd0;
        if (rsp_valid_s) begin
            bus.rd_rsp_data1 = (rs1_r == 5'd0) ? 32'd0 : (hit1_r ? byp1_r : rf_readOut1);
            bus.rd_rsp_data2 = (rs2_r == 5'd0) ? 32'd0 : (hit2_r ? byp2_r : rf_readOut2);
        end else begin
            bus.rd_rsp_data1 = 32'd0;
            bus.rd_rsp_data2 = 32'd0;
        end
    end

    assign bus.rd_req_ready = rd_req_ready_s;
    assign bus.wb_ready     = wb_ready_s;
    assign bus.rd_rsp_valid = rsp_valid_s;
    assign bus.wb_count     = reset ? 2'd0 : q_cnt_r;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: directed scenarios plus randomized traffic,
// checked cycle by cycle against an architectural register/queue model.
module tb_regfile_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rf_en, rf_reset, rf_readEn, rf_writeEn;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic [31:0] rf_dataIn;
    logic [31:0] rf_readOut1 = 32'd0;
    logic [31:0] rf_readOut2 = 32'd0;
    logic [31:0] rf_mem [32];

    int checks = 0;
    int errors = 0;
    int rst_cnt;

    // Reference model: architectural values, pending write queue, read progress.
    logic [31:0] arch [32];
    logic [36:0] wq [$];
    int          rd_age = -1;      // -1 none, 1 read port cycle, 2 response pending
    bit          clr_pend = 1'b1;
    logic [4:0]  m_rs1, m_rs2;
    logic [31:0] m_d1, m_d2;

    always #5 clk = ~clk;

    regfile_port_ctrl_if bus();

    regfile_port_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .rf_en       (rf_en),
        .rf_reset    (rf_reset),
        .rf_readEn   (rf_readEn),
        .rf_writeEn  (rf_writeEn),
        .rf_rs1      (rf_rs1),
        .rf_rs2      (rf_rs2),
        .rf_rd       (rf_rd),
        .rf_dataIn   (rf_dataIn),
        .rf_readOut1 (rf_readOut1),
        .rf_readOut2 (rf_readOut2)
    );

    // Simple register-file memory attached to the rf_* side.
    always @(posedge clk) begin
        if (rf_en && rf_reset) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
        end else begin
            if (rf_writeEn) rf_mem[rf_rd] <= rf_dataIn;
            if (rf_readEn) begin
                rf_readOut1 <= rf_mem[rf_rs1];
                rf_readOut2 <= rf_mem[rf_rs2];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rst, input bit rqv, input logic [4:0] r1, input logic [4:0] r2,
                        input bit rspr, input bit wv, input logic [4:0] wrd, input logic [31:0] wd);
        bit e_clear, e_idle, e_issue, e_rsp, e_wbr, e_drain;
        @(negedge clk);
        reset            = rst;
        bus.rd_req_valid = rqv;
        bus.rd_req_rs1   = r1;
        bus.rd_req_rs2   = r2;
        bus.rd_rsp_ready = rspr;
        bus.wb_valid     = wv;
        bus.wb_rd        = wrd;
        bus.wb_data      = wd;
        #1;
        e_clear = !rst && clr_pend;
        e_idle  = !rst && !clr_pend && (rd_age < 0);
        e_issue = !rst && (rd_age == 1);
        e_rsp   = !rst && (rd_age >= 2);
        e_wbr   = !rst && !clr_pend && (wq.size() < 2);
        e_drain = (e_idle || e_rsp) && (wq.size() > 0);
        chk("rd_req_ready", 64'(bus.rd_req_ready), 64'(e_idle));
        chk("wb_ready",     64'(bus.wb_ready),     64'(e_wbr));
        chk("wb_count",     64'(bus.wb_count),     rst ? 64'd0 : 64'(wq.size()));
        chk("rf_reset",     64'(rf_reset),         64'(rst || e_clear));
        chk("rf_readEn",    64'(rf_readEn),        64'(e_issue));
        chk("rf_writeEn",   64'(rf_writeEn),       64'(e_drain));
        chk("rf_en",        64'(rf_en),            64'(rst || e_clear || e_issue || e_drain));
        chk("rsp_valid",    64'(bus.rd_rsp_valid), 64'(e_rsp));
        chk("rsp_data1",    64'(bus.rd_rsp_data1), e_rsp ? 64'(m_d1) : 64'd0);
        chk("rsp_data2",    64'(bus.rd_rsp_data2), e_rsp ? 64'(m_d2) : 64'd0);
        if (e_issue) begin
            chk("rf_rs1", 64'(rf_rs1), 64'(m_rs1));
            chk("rf_rs2", 64'(rf_rs2), 64'(m_rs2));
        end
        if (e_drain) begin
            chk("rf_rd",     64'(rf_rd),     64'(wq[0][36:32]));
            chk("rf_dataIn", 64'(rf_dataIn), 64'(wq[0][31:0]));
        end
        if (rst) begin
            chk("rst_rf_sel", 64'({rf_rs1, rf_rs2, rf_rd}), 64'd0);
            chk("rst_rf_din", 64'(rf_dataIn), 64'd0);
        end
        if (rst) begin
            wq.delete();
            rd_age   = -1;
            clr_pend = 1'b1;
            for (int i = 0; i < 32; i++) arch[i] = 32'd0;
        end else begin
            if (e_drain) void'(wq.pop_front());
            if (wv && e_wbr && (wrd != 5'd0)) begin
                wq.push_back({wrd, wd});
                arch[wrd] = wd;
            end
            if (e_idle && rqv) begin
                rd_age = 1;
                m_rs1 = r1;
                m_rs2 = r2;
                m_d1  = arch[r1];
                m_d2  = arch[r2];
            end else if (rd_age == 1) begin
                rd_age = 2;
            end else if (e_rsp && rspr) begin
                rd_age = -1;
            end
            clr_pend = 1'b0;
        end
    endtask

    task automatic idle(input bit rspr);
        step(1'b0, 1'b0, 5'd0, 5'd0, rspr, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        bit saw_valid;
        reset = 1'b1;
        bus.rd_req_valid = 1'b0; bus.rd_req_rs1 = 5'd0; bus.rd_req_rs2 = 5'd0;
        bus.rd_rsp_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
        for (int i = 0; i < 32; i++) arch[i] = 32'd0;

        // Reset for 3 cycles, one CLEAR cycle, ready on the 5th.
        rst_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
            if (rf_reset) rst_cnt++;
        end
        idle(1'b1);
        if (rf_reset) rst_cnt++;
        idle(1'b1);
        if (rf_reset) rst_cnt++;
        chk("rst_len", 64'(rst_cnt), 64'd4);
        chk("rst_rdy_rd", 64'(bus.rd_req_ready), 64'd1);
        chk("rst_rdy_wb", 64'(bus.wb_ready), 64'd1);

        // Single write drains next cycle.
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        idle(1'b1);
        chk("wr_en", 64'(rf_writeEn), 64'd1);
        chk("wr_rd", 64'(rf_rd), 64'd5);
        chk("wr_data", 64'(rf_dataIn), 64'hDEADBEEF);
        idle(1'b1);
        chk("wr_cnt0", 64'(bus.wb_count), 64'd0);

        // Same-cycle write and read: bypass.
        step(1'b0, 1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 32'h11);
        idle(1'b1);
        idle(1'b1);
        chk("byp_valid", 64'(bus.rd_rsp_valid), 64'd1);
        chk("byp_d1", 64'(bus.rd_rsp_data1), 64'h11);
        chk("byp_d2", 64'(bus.rd_rsp_data2), 64'd0);
        chk("byp_drain", 64'({rf_writeEn, rf_rd}), 64'({1'b1, 5'd7}));

        // Two writes to x3, youngest value read back.
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 32'hA);
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 32'hB);
        step(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 1'b0, 5'd0, 32'd0);
        idle(1'b1);
        idle(1'b1);
        chk("young_d1", 64'(bus.rd_rsp_data1), 64'hB);
        chk("young_d2", 64'(bus.rd_rsp_data2), 64'hB);

        // Fill the queue, then hold the response for 5 cycles.
        step(1'b0, 1'b1, 5'd5, 5'd7, 1'b0, 1'b1, 5'd9, 32'h99);
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd10, 32'hAA);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 1'b1, 5'd11, 32'h77);
            if (i == 0) begin
                chk("full_cnt", 64'(bus.wb_count), 64'd2);
                chk("full_wbr", 64'(bus.wb_ready), 64'd0);
            end
            chk("hold_valid", 64'(bus.rd_rsp_valid), 64'd1);
            chk("hold_d1", 64'(bus.rd_rsp_data1), 64'hDEADBEEF);
            chk("hold_d2", 64'(bus.rd_rsp_data2), 64'h11);
            chk("hold_rdy", 64'(bus.rd_req_ready), 64'd0);
        end
        chk("hold_drained", 64'(wq.size()), 64'd1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("drain_cnt0", 64'(bus.wb_count), 64'd0);

        // Write to x0 is swallowed.
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h55);
        idle(1'b1);
        chk("x0_wen", 64'(rf_writeEn), 64'd0);
        chk("x0_cnt", 64'(bus.wb_count), 64'd0);

        // Reset during the read-port cycle aborts the read and the queue.
        step(1'b0, 1'b1, 5'd5, 5'd12, 1'b1, 1'b1, 5'd12, 32'h12);
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (bus.rd_rsp_valid) saw_valid = 1'b1;
            chk("abort_cnt", 64'(bus.wb_count), 64'd0);
        end
        chk("abort_valid", 64'(saw_valid), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 7)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
